// File: rtl/ex_stage_div.sv
// Execute stage with logic/shift/arith/move ALU and a multi-cycle restoring divider.
// Divide results are written to HI (remainder) and LO (quotient).

package ex_stage_div_pkg;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

endpackage

module ex_stage_div
    import ex_stage_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  ex_aluop,
    input  logic [2:0]  ex_alusel,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic [4:0]  ex_wd_addr,
    input  logic        ex_wreg,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BYZERO,
        DIV_ON,
        DIV_END
    } div_state_t;

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        is_div;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic [31:0] move_res;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no case path infers a latch.
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;

        case (ex_aluop)
            OP_OR:   logic_res = ex_reg1 | ex_reg2;
            OP_AND:  logic_res = ex_reg1 & ex_reg2;
            OP_XOR:  logic_res = ex_reg1 ^ ex_reg2;
            OP_NOR:  logic_res = ~(ex_reg1 | ex_reg2);
            default: logic_res = '0;
        endcase

        case (ex_aluop)
            OP_SLL:  shift_res = ex_reg2 << ex_reg1[4:0];
            OP_SRL:  shift_res = ex_reg2 >> ex_reg1[4:0];
            OP_SRA:  shift_res = 32'($signed(ex_reg2) >>> ex_reg1[4:0]);
            default: shift_res = '0;
        endcase

        case (ex_aluop)
            OP_ADDU: arith_res = ex_reg1 + ex_reg2;
            OP_SUBU: arith_res = ex_reg1 - ex_reg2;
            OP_SLT:  arith_res = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
            OP_SLTU: arith_res = {31'd0, ex_reg1 < ex_reg2};
            default: arith_res = '0;
        endcase

        case (ex_aluop)
            OP_MFHI: move_res = hi_i;
            OP_MFLO: move_res = lo_i;
            default: move_res = '0;
        endcase

        case (ex_alusel)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_ARITH: wdata_o = arith_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
        endcase
    end

    assign is_div    = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    assign is_signed = (ex_aluop == OP_DIV);
    assign wd_o      = ex_wd_addr;
    assign wreg_o    = is_div ? 1'b0 : ex_wreg;

    // ------------------------------------------------------------------
    // Divider: operands are converted to magnitudes at launch, signs fixed up at the end
    // ------------------------------------------------------------------
    assign a_neg = is_signed && ex_reg1[31];
    assign b_neg = is_signed && ex_reg2[31];
    assign a_mag = a_neg ? (~ex_reg1 + 32'd1) : ex_reg1;
    assign b_mag = b_neg ? (~ex_reg2 + 32'd1) : ex_reg2;

    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dsr_q};

    assign quo_fin = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fin = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (!rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush) begin
            state <= DIV_FREE;
            cnt   <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (is_div) begin
                        quo_q     <= a_mag;
                        dsr_q     <= b_mag;
                        rem_q     <= '0;
                        cnt       <= '0;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        state     <= (ex_reg2 == 32'd0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    quo_q     <= '0;
                    rem_q     <= '0;
                    neg_quo_q <= 1'b0;
                    neg_rem_q <= 1'b0;
                    state     <= DIV_END;
                end
                DIV_ON: begin
                    // Restore when the trial subtraction borrows, otherwise keep the difference.
                    if (trial[32]) begin
                        rem_q <= shifted[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end else begin
                        rem_q <= trial[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DIV_END;
                    end
                end
                DIV_END: begin
                    cnt   <= '0;
                    state <= DIV_FREE;
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

    // HI/LO write port and stall request; everything is quiet while reset is held.
    always_comb begin
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            case (state)
                DIV_FREE:   stallreq_o = is_div;
                DIV_BYZERO: stallreq_o = 1'b1;
                DIV_ON:     stallreq_o = 1'b1;
                default:    stallreq_o = 1'b0;
            endcase

            if (state == DIV_END) begin
                whilo_o = 1'b1;
                hi_o    = rem_fin;
                lo_o    = quo_fin;
            end else if (ex_aluop == OP_MTHI) begin
                whilo_o = 1'b1;
                hi_o    = ex_reg1;
                lo_o    = lo_i;
            end else if (ex_aluop == OP_MTLO) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = ex_reg1;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_div.sv
// Scoreboard bench for ex_stage_div: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and flags any unexpected HI/LO write.

module tb_ex_stage_div;
    import ex_stage_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd_addr;
    logic        ex_wreg;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    exp_t sb[$];

    ex_stage_div dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ex_aluop   (ex_aluop),
        .ex_alusel  (ex_alusel),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_wd_addr (ex_wd_addr),
        .ex_wreg    (ex_wreg),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wr);
        ex_aluop   = op;
        ex_alusel  = sel;
        ex_reg1    = r1;
        ex_reg2    = r2;
        ex_wd_addr = wd;
        ex_wreg    = wr;
    endtask

    task automatic expect_at(input string name, input int ofs, input logic [31:0] wdata,
                             input logic wreg, input logic whilo, input logic [31:0] hi,
                             input logic [31:0] lo, input logic stall);
        exp_t e;
        e.name  = name;
        e.cyc   = cyc + ofs;
        e.wd    = ex_wd_addr;
        e.wdata = wdata;
        e.wreg  = wreg;
        e.whilo = whilo;
        e.hi    = hi;
        e.lo    = lo;
        e.stall = stall;
        sb.push_back(e);
    endtask

    task automatic alu_vec(input string name, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp_wdata);
        set_op(op, sel, r1, r2, 5'(cyc), 1'b1);
        expect_at(name, 0, exp_wdata, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    task automatic idle(input string name, input int n);
        set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            expect_at(name, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
    endtask

    // Full divide: stalled cycles, the single result cycle, then one idle cycle.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        set_op(sgn ? OP_DIV : OP_DIVU, SEL_NOP, a, b, 5'd9, 1'b1);
        for (int i = 0; i < lat; i++) begin
            expect_at({name, "_stall"}, i, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        expect_at({name, "_result"}, lat, 32'd0, 1'b0, 1'b1, r, q, 1'b0);
        tick();
        ex_reg1 = ~a;
        ex_reg2 = b ^ 32'h5;
        repeat (lat) tick();
        set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        expect_at({name, "_idle"}, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    // Monitor: compares queued expectations on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_tests++;
                if ({wd_o, wdata_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o} !==
                    {e.wd, e.wdata, e.wreg, e.whilo, e.hi, e.lo, e.stall}) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got wd=%0d wdata=%h wreg=%b whilo=%b hi=%h lo=%h stall=%b; want wd=%0d wdata=%h wreg=%b whilo=%b hi=%h lo=%h stall=%b",
                             e.name, cyc, wd_o, wdata_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o,
                             e.wd, e.wdata, e.wreg, e.whilo, e.hi, e.lo, e.stall);
                end
            end else if (whilo_o !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_whilo @cyc %0d: whilo=%b hi=%h lo=%h, want no write", cyc, whilo_o, hi_o, lo_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        hi_i  = 32'hDEAD_BEEF;
        lo_i  = 32'h1234_5678;
        set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();

        // Divide presented during reset must not stall or start.
        set_op(OP_DIV, SEL_NOP, 32'd5, 32'd3, 5'd3, 1'b1);
        expect_at("reset_div_gated", 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        expect_at("reset_hold", 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        idle("after_reset", 2);

        alu_vec("ori_or",   OP_OR,   SEL_LOGIC, 32'h0000_1100, 32'h0000_0020, 32'h0000_1120);
        alu_vec("and",      OP_AND,  SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu_vec("xor",      OP_XOR,  SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        alu_vec("nor",      OP_NOR,  SEL_LOGIC, 32'h0000_00FF, 32'h0000_FF00, 32'hFFFF_0000);
        alu_vec("sll",      OP_SLL,  SEL_SHIFT, 32'd4,         32'h0000_0013, 32'h0000_0130);
        alu_vec("sll_amt5", OP_SLL,  SEL_SHIFT, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010);
        alu_vec("srl",      OP_SRL,  SEL_SHIFT, 32'd8,         32'h8000_0000, 32'h0080_0000);
        alu_vec("sra",      OP_SRA,  SEL_SHIFT, 32'd4,         32'h8000_0000, 32'hF800_0000);
        alu_vec("addu",     OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2,         32'd1);
        alu_vec("subu",     OP_SUBU, SEL_ARITH, 32'd0,         32'd1,         32'hFFFF_FFFF);
        alu_vec("slt_m1_1", OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         32'd1);
        alu_vec("slt_1_m1", OP_SLT,  SEL_ARITH, 32'd1,         32'hFFFF_FFFF, 32'd0);
        alu_vec("sltu",     OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         32'd0);
        alu_vec("mfhi",     OP_MFHI, SEL_MOVE,  32'd0,         32'd0,         32'hDEAD_BEEF);
        alu_vec("mflo",     OP_MFLO, SEL_MOVE,  32'd0,         32'd0,         32'h1234_5678);
        alu_vec("bad_sel",  OP_OR,   3'b111,    32'h0000_0001, 32'h0000_0002, 32'd0);

        set_op(OP_MTHI, SEL_NOP, 32'hAAAA_5555, 32'd0, 5'd0, 1'b0);
        expect_at("mthi", 0, 32'd0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 1'b0);
        tick();
        set_op(OP_MTLO, SEL_NOP, 32'h0000_0F0F, 32'd0, 5'd0, 1'b0);
        expect_at("mtlo", 0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0F0F, 1'b0);
        tick();

        run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div_m8_m3",   1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE);
        run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
        run_div("divu_5_9",    1'b0, 32'd5,         32'd9,         32'd0,         32'd5);
        run_div("div_by_zero", 1'b1, 32'd123,       32'd0,         32'd0,         32'd0);

        // Flush at iteration 10 aborts the divide without a HI/LO write.
        set_op(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            expect_at("flush_it10_stall", i, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle("flush_it10_after", 36);

        // Reset at iteration 20 aborts the divide the same way.
        set_op(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        for (int i = 0; i < 20; i++) begin
            expect_at("rst_it20_stall", i, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        repeat (20) tick();
        rst = 1'b0;
        expect_at("rst_it20_gated", 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        idle("rst_it20_after", 36);

        // Flush coincident with a divide in FREE must not launch it.
        set_op(OP_DIV, SEL_NOP, 32'd50, 32'd5, 5'd9, 1'b1);
        flush = 1'b1;
        expect_at("flush_at_issue", 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        tick();
        flush = 1'b0;
        idle("flush_at_issue_after", 36);

        run_div("divu_recover", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        idle("tail", 3);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_div.md
EX_STAGE_DIV -- requirements
Module: ex_stage_div

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous and active-low; block resets on a posedge clk where rst==0.
REQ-003 flush  input  1  pipeline flush; aborts any in-flight divide.
REQ-004 ex_aluop  input  8  operation code, encodings per shared defines header.
REQ-005 ex_alusel  input  3  result class: NOP, LOGIC, SHIFT, ARITH, MOVE.
REQ-006 ex_reg1 / ex_reg2  input  32 each  operand A / operand B.
REQ-007 ex_wd_addr  input  5  destination register address.
REQ-008 ex_wreg  input  1  destination write enable.
REQ-009 hi_i / lo_i  input  32 each  current HI/LO register values, already forwarded.
REQ-010 wd_o  output  5  destination address, passed through from ex_wd_addr.
REQ-011 wreg_o  output  1  write enable, passed through from ex_wreg.
REQ-012 wdata_o  output  32  GPR write data.
REQ-013 whilo_o  output  1  HI/LO write strobe.
REQ-014 hi_o / lo_o  output  32 each  HI/LO write data.
REQ-015 stallreq_o  output  1  request that the pipeline controller hold IF/ID/EX.

Function
REQ-016 Logic ops, combinational on operands: OR, AND, XOR, NOR.
REQ-017 Shift ops: SLL, SRL, SRA; shift amount ex_reg1[4:0], shifted value ex_reg2; SRA replicates bit 31.
REQ-018 Arithmetic ops: ADDU, SUBU, SLT (signed compare), SLTU (unsigned compare); SLT/SLTU produce 32'd1 or 32'd0; no overflow detection.
REQ-019 Move ops: MFHI gives wdata_o=hi_i; MFLO gives wdata_o=lo_i; MTHI/MTLO give whilo_o=1, with the written half = ex_reg1 and the other half = its current value.
REQ-020 wdata_o selected by ex_alusel; NOP or unknown class gives 0.
REQ-021 DIV (signed) and DIVU (unsigned): quotient goes to lo_o, remainder to hi_o; wreg_o is forced 0.
REQ-022 Divider FSM states: FREE, BYZERO, ON, END.
REQ-023 FREE: on DIV/DIVU with no flush, go to ON if ex_reg2!=0, else BYZERO; otherwise stay FREE.
REQ-024 BYZERO: quotient=0, remainder=0, go to END next edge.
REQ-025 ON: one restoring shift-subtract iteration per cycle; 6-bit counter; go to END after iteration 32.
REQ-026 Signed divide: divide operand magnitudes. Quotient is negated iff the operand signs differ. Remainder takes the sign of the dividend.
REQ-027 END: whilo_o=1 with the final hi_o/lo_o for exactly one cycle; stallreq_o=0; unconditionally go to FREE next edge.
REQ-028 stallreq_o=1 in these cases: in FREE while a divide is presented, in BYZERO, and in ON; otherwise 0.
REQ-029 Latency: a divide presented at cycle N gives its result on cycle N+33 (nonzero divisor) or N+2 (zero divisor).
REQ-030 Operands are latched on the FREE->ON/BYZERO transition; later input changes are ignored until FREE.
REQ-031 flush=1 in any state forces FREE on the next edge with no whilo_o pulse; a flush coincident with a divide in FREE does not start it.
REQ-032 whilo_o=0, hi_o=0, lo_o=0 whenever not in END and no MTHI/MTLO.

Reset
REQ-033 rst==0 at posedge forces FREE, counter=0, and clears the latched operands and partial remainder.
REQ-034 While in reset or in FREE with no divide, stallreq_o=0 and whilo_o=0.
REQ-035 Reset mid-divide aborts it; no result is produced.

Verification
REQ-036 ORI-style LOGIC OR, reg1=32'h0000_1100, reg2=32'h0000_0020 -> wdata_o=32'h0000_1120, wreg_o follows ex_wreg, whilo_o=0.
REQ-037 DIVU reg1=100, reg2=7 at cycle N -> stallreq_o=1 on cycles N..N+32; cycle N+33: lo_o=14, hi_o=2, whilo_o=1, wreg_o=0.
REQ-038 DIV reg1=-7 (32'hFFFF_FFF9), reg2=2 -> lo_o=32'hFFFF_FFFD (-3), hi_o=32'hFFFF_FFFF (-1).
REQ-039 DIV reg2=0 at cycle N -> stallreq_o=1 on cycles N..N+1; cycle N+2: hi_o=0, lo_o=0, whilo_o=1.
REQ-040 DIVU in progress; flush=1 at iteration 10 -> FREE next cycle, stallreq_o=0, no whilo_o pulse. Repeat with rst=0 at iteration 20 -> same outcome.
REQ-041 SRA reg1=4, reg2=32'h8000_0000 -> wdata_o=32'hF800_0000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
